arq_flow_engine: RTL and testbench

Parametrised per-logical-transport ARQ/SEQN/FLOW engine for the baseband link controller. It keeps per-LT_ADDR TX SEQN, RX SEQN_old, outgoing ARQN, remote FLOW, last received ARQN, and flush/retransmit state. At each TX header it decides whether to send a new, old, or zero-length payload, and it evaluates RX header and payload events per Vol2 PartB 7.6. It sits between the packet header decoder/encoder and the ACL TX/RX buffer controllers.

---
 rtl/arq_flow_if.sv | 57 +++++
 rtl/arq_flow_engine.sv | 250 +++++++++++++++++++++++++
 tb/tb_arq_flow_engine.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/arq_flow_if.sv
// ---------------------------------------------------------------------------
// arq_flow_if
// Bundles the header decoder/encoder strobes and the per-LT ARQ state
// outputs that connect to arq_flow_engine.
//   master : header codec side (drives strobes, reads ARQ state)
//   slave  : arq_flow_engine
// Parameters: NLT entries, AW-bit LT_ADDR index.
// ---------------------------------------------------------------------------
interface arq_flow_if #(
  parameter int NLT = 8,
  parameter int AW  = 3
);
  logic           link_init_p;
  logic [AW-1:0]  link_lt;
  logic           is_master;
  logic           tx_hdr_p;
  logic [AW-1:0]  tx_lt;
  logic           tx_data;
  logic           rx_hdr_p;
  logic           rx_hdr_ok;
  logic           rx_addressed;
  logic [AW-1:0]  rx_lt;
  logic           rx_data;
  logic           rx_seqn;
  logic           rx_arqn;
  logic           rx_flow;
  logic           rx_py_end_p;
  logic           rx_py_ok;
  logic           rx_notrig_p;
  logic           flush_p;
  logic [AW-1:0]  flush_lt;
  logic [NLT-1:0] tx_seqn;
  logic [NLT-1:0] tx_arqn;
  logic [NLT-1:0] seqn_old;
  logic [NLT-1:0] rem_flow;
  logic [1:0]     tx_sel;
  logic           rx_accept_p;
  logic           flush_done_p;

  modport master (
    output link_init_p, link_lt, is_master, tx_hdr_p, tx_lt, tx_data,
           rx_hdr_p, rx_hdr_ok, rx_addressed, rx_lt, rx_data, rx_seqn,
           rx_arqn, rx_flow, rx_py_end_p, rx_py_ok, rx_notrig_p,
           flush_p, flush_lt,
    input  tx_seqn, tx_arqn, seqn_old, rem_flow, tx_sel, rx_accept_p,
           flush_done_p
  );

  modport slave (
    input  link_init_p, link_lt, is_master, tx_hdr_p, tx_lt, tx_data,
           rx_hdr_p, rx_hdr_ok, rx_addressed, rx_lt, rx_data, rx_seqn,
           rx_arqn, rx_flow, rx_py_end_p, rx_py_ok, rx_notrig_p,
           flush_p, flush_lt,
    output tx_seqn, tx_arqn, seqn_old, rem_flow, tx_sel, rx_accept_p,
           flush_done_p
  );
endinterface

// File: rtl/arq_flow_engine.sv
// ---------------------------------------------------------------------------
// arq_flow_engine
// Per-logical-transport ARQ/SEQN/FLOW engine. Keeps TX SEQN, RX SEQN_old,
// outgoing ARQN, remote FLOW, last received ARQN and flush state per LT_ADDR,
// picks new/old/zero-length payload at each TX header and evaluates RX
// header/payload events.
// Ports:
//   clk_6M   baseband clock
//   rstz     asynchronous active-low reset
//   bus      arq_flow_if.slave (strobes in, per-LT state and pulses out)
// Optional build macro: ARQ_RTX_LIMIT_EN -- per-LT retransmit counters that
//   force a flush after MAX_RTX old-payload decisions (MAX_RTX=0 disables).
//
// RX payload state:
//   state      | meaning
//   RX_IDLE    | no payload pending
//   RX_WAIT_PY | new-SEQN header accepted for pend_r, waiting for payload end
// ---------------------------------------------------------------------------
module arq_flow_engine #(
  parameter int NLT     = 8,
  parameter int AW      = 3,
  parameter int RTX_W   = 4,
  parameter int MAX_RTX = 15
) (
  input logic       clk_6M,
  input logic       rstz,
  arq_flow_if.slave bus
);

  if (NLT > 2**AW || RTX_W < 1 || MAX_RTX < 0 || MAX_RTX >= 2**RTX_W) begin : g_bad_cfg
    $error("arq_flow_engine: inconsistent parameters");
  end

  typedef enum logic [0:0] {RX_IDLE, RX_WAIT_PY} rx_state_t;

  rx_state_t      rx_state;
  logic [AW-1:0]  pend_r;
  logic           pend_seqn;
  logic [AW-1:0]  last_tx_lt;
  logic [NLT-1:0] tx_seqn, tx_arqn, seqn_old, rem_flow;
  logic [NLT-1:0] ack_seen, flush_pend, flush_hold;
  logic [1:0]     tx_sel;
  logic           rx_accept_p, flush_done_p;

  logic [NLT-1:0] seqn_n, arqn_n, old_n, flow_n, ack_n, fp_n, hold_n;
  logic [1:0]     sel_n;
  logic           acc_n, done_n;
  logic [AW-1:0]  last_n;

`ifdef ARQ_RTX_LIMIT_EN
  localparam logic [RTX_W-1:0] RTX_LIMIT = RTX_W'(MAX_RTX);
  logic [RTX_W-1:0] rtx   [NLT];
  logic [RTX_W-1:0] rtx_n [NLT];
`endif

  function automatic logic [NLT-1:0] onehot(input logic [AW-1:0] idx);
    logic [NLT-1:0] v;
    v = '0;
    for (int i = 0; i < NLT; i++)
      if (idx == AW'(i)) v[i] = 1'b1;
    return v;
  endfunction

  logic [NLT-1:0] init_oh, rx_oh, tx_oh, py_oh, miss_m, flush_req;
  logic [NLT-1:0] m_notrig, m_hdr, m_py, m_tx, busy2, busy3, busy4, busy5;
  logic           go_notrig, go_hdr, go_py, go_tx, py_arm, rx_dup, rx_new;

  // Each strobe claims the entries it touches; a lower-priority strobe that
  // overlaps an already-claimed entry is dropped (flushes are held instead).
  always_comb begin
    init_oh   = bus.link_init_p ? onehot(bus.link_lt) : '0;
    rx_oh     = onehot(bus.rx_lt);
    tx_oh     = onehot(bus.tx_lt);
    py_oh     = onehot(pend_r);
    miss_m    = bus.is_master ? onehot(last_tx_lt) : '1;
    rx_dup    = (bus.rx_seqn == |(seqn_old & rx_oh));
    rx_new    = bus.rx_hdr_ok & bus.rx_addressed & bus.rx_data & !rx_dup;
    // A header in the same cycle supersedes any pending payload.
    py_arm    = bus.rx_py_end_p & (rx_state == RX_WAIT_PY) & !bus.rx_hdr_p;

    m_notrig  = bus.rx_notrig_p ? miss_m : '0;
    m_hdr     = !bus.rx_hdr_p      ? '0 :
                !bus.rx_hdr_ok     ? miss_m :
                bus.rx_addressed   ? rx_oh : '0;
    m_py      = py_arm ? py_oh : '0;
    m_tx      = (bus.tx_hdr_p & bus.tx_data) ? tx_oh : '0;

    go_notrig = bus.rx_notrig_p && ((m_notrig & init_oh) == '0);
    busy2     = init_oh | (go_notrig ? m_notrig : '0);
    go_hdr    = bus.rx_hdr_p && ((m_hdr & busy2) == '0);
    busy3     = busy2 | (go_hdr ? m_hdr : '0);
    go_py     = py_arm && ((m_py & busy3) == '0);
    busy4     = busy3 | (go_py ? m_py : '0);
    go_tx     = bus.tx_hdr_p && ((m_tx & busy4) == '0);
    busy5     = busy4 | (go_tx ? m_tx : '0);
    flush_req = flush_hold | (bus.flush_p ? onehot(bus.flush_lt) : '0);
  end

  always_comb begin
    seqn_n = tx_seqn;
    arqn_n = tx_arqn;
    old_n  = seqn_old;
    flow_n = rem_flow;
    ack_n  = ack_seen;
    fp_n   = flush_pend;
    sel_n  = tx_sel;
    last_n = last_tx_lt;
    acc_n  = 1'b0;
    done_n = 1'b0;
`ifdef ARQ_RTX_LIMIT_EN
    rtx_n  = rtx;
    for (int i = 0; i < NLT; i++)
      if (init_oh[i]) rtx_n[i] = '0;
`endif

    seqn_n &= ~init_oh;
    old_n  &= ~init_oh;
    arqn_n &= ~init_oh;
    fp_n   &= ~init_oh;
    flow_n |= init_oh;
    ack_n  |= init_oh;

    if (go_notrig) arqn_n &= ~miss_m;

    if (go_hdr) begin
      if (!bus.rx_hdr_ok) begin
        arqn_n &= ~miss_m;
      end else if (bus.rx_addressed) begin
        ack_n  = bus.rx_arqn ? (ack_n | rx_oh) : (ack_n & ~rx_oh);
        flow_n = bus.rx_flow ? (flow_n | rx_oh) : (flow_n & ~rx_oh);
        if (bus.rx_data && rx_dup) arqn_n |= rx_oh;
      end
    end

    if (go_py) begin
      if (bus.rx_py_ok) begin
        old_n  = pend_seqn ? (old_n | py_oh) : (old_n & ~py_oh);
        arqn_n |= py_oh;
        acc_n  = 1'b1;
      end else begin
        arqn_n &= ~py_oh;
      end
    end

    if (bus.tx_hdr_p) begin
      sel_n = 2'b00;
      if (go_tx) begin
        last_n = bus.tx_lt;
        if (bus.tx_data) begin
          if (|(flush_pend & tx_oh)) begin
            sel_n  = 2'b11;
            seqn_n ^= tx_oh;
            fp_n   &= ~tx_oh;
            done_n = 1'b1;
`ifdef ARQ_RTX_LIMIT_EN
            for (int i = 0; i < NLT; i++) if (tx_oh[i]) rtx_n[i] = '0;
`endif
          end else if (|(ack_seen & rem_flow & tx_oh)) begin
            sel_n  = 2'b01;
            seqn_n ^= tx_oh;
`ifdef ARQ_RTX_LIMIT_EN
            for (int i = 0; i < NLT; i++) if (tx_oh[i]) rtx_n[i] = '0;
`endif
          end else begin
            sel_n = 2'b10;
`ifdef ARQ_RTX_LIMIT_EN
            for (int i = 0; i < NLT; i++) begin
              if (tx_oh[i]) begin
                if (rtx[i] != '1) rtx_n[i] = rtx[i] + 1'b1;
                if (MAX_RTX != 0 && rtx_n[i] == RTX_LIMIT) fp_n[i] = 1'b1;
              end
            end
`endif
          end
        end
      end
    end

    fp_n   |= flush_req & ~busy5;
    hold_n  = flush_req & busy5;
  end

  always_ff @(posedge clk_6M or negedge rstz) begin
    if (!rstz) begin
      rx_state     <= RX_IDLE;
      pend_r       <= '0;
      pend_seqn    <= 1'b0;
      last_tx_lt   <= '0;
      tx_seqn      <= '0;
      tx_arqn      <= '0;
      seqn_old     <= '0;
      rem_flow     <= '1;
      ack_seen     <= '1;
      flush_pend   <= '0;
      flush_hold   <= '0;
      tx_sel       <= 2'b00;
      rx_accept_p  <= 1'b0;
      flush_done_p <= 1'b0;
`ifdef ARQ_RTX_LIMIT_EN
      for (int i = 0; i < NLT; i++) rtx[i] <= '0;
`endif
    end else begin
      tx_seqn      <= seqn_n;
      tx_arqn      <= arqn_n;
      seqn_old     <= old_n;
      rem_flow     <= flow_n;
      ack_seen     <= ack_n;
      flush_pend   <= fp_n;
      flush_hold   <= hold_n;
      tx_sel       <= sel_n;
      last_tx_lt   <= last_n;
      rx_accept_p  <= acc_n;
      flush_done_p <= done_n;
`ifdef ARQ_RTX_LIMIT_EN
      rtx          <= rtx_n;
`endif
      case (rx_state)
        RX_IDLE: begin
          if (bus.rx_hdr_p && go_hdr && rx_new) begin
            rx_state  <= RX_WAIT_PY;
            pend_r    <= bus.rx_lt;
            pend_seqn <= bus.rx_seqn;
          end
        end
        RX_WAIT_PY: begin
          if (bus.rx_hdr_p) begin
            if (go_hdr && rx_new) begin
              pend_r    <= bus.rx_lt;
              pend_seqn <= bus.rx_seqn;
            end else begin
              rx_state <= RX_IDLE;
            end
          end else if (py_arm) begin
            rx_state <= RX_IDLE;
          end
        end
        default: rx_state <= RX_IDLE;
      endcase
    end
  end

  assign bus.tx_seqn      = tx_seqn;
  assign bus.tx_arqn      = tx_arqn;
  assign bus.seqn_old     = seqn_old;
  assign bus.rem_flow     = rem_flow;
  assign bus.tx_sel       = tx_sel;
  assign bus.rx_accept_p  = rx_accept_p;
  assign bus.flush_done_p = flush_done_p;

endmodule

// File: tb/tb_arq_flow_engine.sv
// ---------------------------------------------------------------------------
// tb_arq_flow_engine
// Self-checking bench for arq_flow_engine: directed scenarios plus random
// single-strobe traffic, compared against a per-LT behavioural model.
// ---------------------------------------------------------------------------
module tb_arq_flow_engine;
  localparam int NLT = 8, AW = 3, RTX_W = 4, MAX_RTX = 15;

  logic clk_6M = 1'b0;
  logic rstz   = 1'b0;
  always #5 clk_6M = ~clk_6M;

  arq_flow_if #(.NLT(NLT), .AW(AW)) bus();

  arq_flow_engine #(.NLT(NLT), .AW(AW), .RTX_W(RTX_W), .MAX_RTX(MAX_RTX)) dut (
    .clk_6M(clk_6M),
    .rstz  (rstz),
    .bus   (bus.slave)
  );

  int n_cmp = 0;
  int n_err = 0;

  // behavioural model: one bit per LT in each vector
  bit [NLT-1:0] m_seqn, m_old, m_arqn, m_flow, m_ack, m_fp;
  int           m_rtx [NLT];
  int           m_last;
  bit           m_pv, m_pseq;
  int           m_plt;
  bit [1:0]     m_sel;
  bit           m_acc, m_done;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".tx_seqn"},  32'(bus.tx_seqn),      32'(m_seqn));
    chk({tag, ".tx_arqn"},  32'(bus.tx_arqn),      32'(m_arqn));
    chk({tag, ".seqn_old"}, 32'(bus.seqn_old),     32'(m_old));
    chk({tag, ".rem_flow"}, 32'(bus.rem_flow),     32'(m_flow));
    chk({tag, ".tx_sel"},   32'(bus.tx_sel),       32'(m_sel));
    chk({tag, ".accept"},   32'(bus.rx_accept_p),  32'(m_acc));
    chk({tag, ".fdone"},    32'(bus.flush_done_p), 32'(m_done));
  endtask

  task automatic mdl_reset();
    m_seqn = '0; m_old = '0; m_arqn = '0; m_flow = '1; m_ack = '1; m_fp = '0;
    for (int i = 0; i < NLT; i++) m_rtx[i] = 0;
    m_last = 0; m_pv = 0; m_pseq = 0; m_plt = 0;
    m_sel = 2'b00; m_acc = 0; m_done = 0;
  endtask

  task automatic mdl_init(input int i);
    m_seqn[i] = 0; m_old[i] = 0; m_arqn[i] = 0; m_flow[i] = 1; m_ack[i] = 1;
    m_fp[i] = 0; m_rtx[i] = 0;
  endtask

  task automatic mdl_tx(input int t, input bit data);
    m_last = t;
    if (!data) m_sel = 2'b00;
    else if (m_fp[t]) begin
      m_sel = 2'b11; m_seqn[t] = !m_seqn[t]; m_fp[t] = 0; m_rtx[t] = 0; m_done = 1;
    end else if (m_ack[t] && m_flow[t]) begin
      m_sel = 2'b01; m_seqn[t] = !m_seqn[t]; m_rtx[t] = 0;
    end else begin
      m_sel = 2'b10;
      if (m_rtx[t] < 2**RTX_W - 1) m_rtx[t]++;
`ifdef ARQ_RTX_LIMIT_EN
      if (MAX_RTX != 0 && m_rtx[t] == MAX_RTX) m_fp[t] = 1;
`endif
    end
  endtask

  task automatic mdl_miss(input bit master);
    if (master) m_arqn[m_last] = 0;
    else m_arqn = '0;
  endtask

  task automatic mdl_hdr(input bit ok, input bit addr, input int lt, input bit data,
                         input bit seqn, input bit arqn, input bit flow, input bit master);
    m_pv = 0;
    if (!ok) mdl_miss(master);
    else if (addr) begin
      m_ack[lt] = arqn; m_flow[lt] = flow;
      if (data) begin
        if (seqn == m_old[lt]) m_arqn[lt] = 1;
        else begin m_pv = 1; m_plt = lt; m_pseq = seqn; end
      end
    end
  endtask

  task automatic mdl_py(input bit ok);
    if (m_pv) begin
      if (ok) begin m_old[m_plt] = m_pseq; m_arqn[m_plt] = 1; m_acc = 1; end
      else m_arqn[m_plt] = 0;
      m_pv = 0;
    end
  endtask

  task automatic idle_inputs();
    bus.link_init_p = 0; bus.tx_hdr_p = 0; bus.rx_hdr_p = 0;
    bus.rx_py_end_p = 0; bus.rx_notrig_p = 0; bus.flush_p = 0;
  endtask

  // inputs are set at the falling edge; outputs sampled 1 ns after the rise
  task automatic step(input string tag);
    @(posedge clk_6M); #1;
    check_all(tag);
    m_acc = 0; m_done = 0;
    @(negedge clk_6M);
    idle_inputs();
  endtask

  task automatic do_init(input int lt);
    bus.link_init_p = 1; bus.link_lt = AW'(lt);
    mdl_init(lt); step("init");
  endtask

  task automatic do_tx(input int lt, input bit data);
    bus.tx_hdr_p = 1; bus.tx_lt = AW'(lt); bus.tx_data = data;
    mdl_tx(lt, data); step("tx");
  endtask

  task automatic do_hdr(input bit ok, input bit addr, input int lt, input bit data,
                        input bit seqn, input bit arqn, input bit flow, input bit master);
    bus.rx_hdr_p = 1; bus.rx_hdr_ok = ok; bus.rx_addressed = addr; bus.rx_lt = AW'(lt);
    bus.rx_data = data; bus.rx_seqn = seqn; bus.rx_arqn = arqn; bus.rx_flow = flow;
    bus.is_master = master;
    mdl_hdr(ok, addr, lt, data, seqn, arqn, flow, master); step("hdr");
  endtask

  task automatic do_py(input bit ok);
    bus.rx_py_end_p = 1; bus.rx_py_ok = ok;
    mdl_py(ok); step("py");
  endtask

  task automatic do_notrig(input bit master);
    bus.rx_notrig_p = 1; bus.is_master = master;
    mdl_miss(master); step("notrig");
  endtask

  task automatic do_flush(input int lt);
    bus.flush_p = 1; bus.flush_lt = AW'(lt);
    m_fp[lt] = 1; step("flush");
  endtask

  task automatic do_reset();
    rstz = 0;
    mdl_reset();
    repeat (2) @(negedge clk_6M);
    #1 check_all("rst");
    @(negedge clk_6M);
    rstz = 1;
  endtask

  initial begin
    idle_inputs();
    bus.link_lt = '0; bus.is_master = 0; bus.tx_lt = '0; bus.tx_data = 0;
    bus.rx_hdr_ok = 0; bus.rx_addressed = 0; bus.rx_lt = '0; bus.rx_data = 0;
    bus.rx_seqn = 0; bus.rx_arqn = 0; bus.rx_flow = 0; bus.rx_py_ok = 0;
    bus.flush_lt = '0;
    @(negedge clk_6M);
    do_reset();

    // new/new/old decisions
    do_init(1);
    do_tx(1, 1);
    chk("tp_sel_new", 32'(bus.tx_sel), 32'h1);
    chk("tp_seqn1", 32'(bus.tx_seqn[1]), 32'h1);
    do_tx(1, 1);
    chk("tp_sel_new2", 32'(bus.tx_sel), 32'h1);
    do_hdr(1, 1, 1, 0, 0, 0, 1, 0);
    do_tx(1, 1);
    chk("tp_sel_old", 32'(bus.tx_sel), 32'h2);

    // accept, duplicate, CRC failure on lt 2
    do_hdr(1, 1, 2, 1, 1, 1, 1, 0);
    do_py(1);
    chk("tp_old2", 32'(bus.seqn_old[2]), 32'h1);
    do_hdr(1, 1, 2, 1, 1, 1, 1, 0);
    chk("tp_dup_arqn", 32'(bus.tx_arqn[2]), 32'h1);
    do_py(1);
    do_hdr(1, 1, 2, 1, 0, 1, 1, 0);
    do_py(0);
    chk("tp_crc_arqn", 32'(bus.tx_arqn[2]), 32'h0);

    // ARQN clearing on missed RX, slave then master
    do_reset();
    do_hdr(1, 1, 1, 1, 0, 1, 1, 0);
    do_hdr(1, 1, 2, 1, 0, 1, 1, 0);
    chk("tp_arqn06", 32'(bus.tx_arqn), 32'h06);
    do_notrig(0);
    chk("tp_slave_clr", 32'(bus.tx_arqn), 32'h00);
    do_hdr(1, 1, 1, 1, 0, 1, 1, 1);
    do_hdr(1, 1, 2, 1, 0, 1, 1, 1);
    do_tx(2, 0);
    do_notrig(1);
    chk("tp_master_clr", 32'(bus.tx_arqn), 32'h02);
    do_hdr(0, 1, 1, 1, 0, 1, 1, 1);

    // remote flow stop/go on lt 3
    do_hdr(1, 1, 3, 0, 0, 1, 0, 0);
    do_tx(3, 1);
    do_hdr(1, 1, 3, 0, 0, 1, 1, 0);
    do_tx(3, 1);

    // host flush
    do_flush(1);
    do_flush(1);
    do_tx(1, 1);
    chk("tp_flush_sel", 32'(bus.tx_sel), 32'h3);
    step("idle");

    // coincident strobes
    bus.link_init_p = 1; bus.link_lt = 3'd1;
    bus.tx_hdr_p = 1; bus.tx_lt = 3'd1; bus.tx_data = 1;
    mdl_init(1); m_sel = 2'b00;
    step("co_init_tx");
    bus.tx_hdr_p = 1; bus.tx_lt = 3'd2; bus.tx_data = 1;
    bus.flush_p = 1; bus.flush_lt = 3'd2;
    mdl_tx(2, 1); m_fp[2] = 1;
    step("co_tx_flush");
    step("idle");
    do_tx(2, 1);
    chk("co_held_flush", 32'(bus.tx_sel), 32'h3);
    bus.rx_hdr_p = 1; bus.rx_hdr_ok = 1; bus.rx_addressed = 1; bus.rx_lt = 3'd3;
    bus.rx_data = 1; bus.rx_seqn = !m_old[3]; bus.rx_arqn = 0; bus.rx_flow = 1;
    bus.tx_hdr_p = 1; bus.tx_lt = 3'd4; bus.tx_data = 1;
    mdl_hdr(1, 1, 3, 1, !m_old[3], 0, 1, bus.is_master); mdl_tx(4, 1);
    step("co_hdr_tx");
    do_py(1);

    // reset in the middle of a payload
    do_hdr(1, 1, 5, 1, 1, 1, 1, 0);
    rstz = 0;
    mdl_reset();
    #2 check_all("midrst");
    @(negedge clk_6M);
    rstz = 1;
    do_py(1);
    step("idle");

    // random single-strobe traffic
    for (int n = 0; n < 600; n++) begin
      int op;
      op = int'($urandom_range(0, 9));
      case (op)
        0:       do_init(int'($urandom_range(0, NLT - 1)));
        1, 2:    do_tx(int'($urandom_range(0, NLT - 1)), $urandom_range(0, 3) != 0);
        3, 4, 5: do_hdr($urandom_range(0, 5) != 0, $urandom_range(0, 5) != 0,
                        int'($urandom_range(0, NLT - 1)), $urandom_range(0, 3) != 0,
                        1'($urandom), 1'($urandom), $urandom_range(0, 3) != 0, 1'($urandom));
        6, 7:    do_py($urandom_range(0, 3) != 0);
        8:       do_notrig(1'($urandom));
        default: do_flush(int'($urandom_range(0, NLT - 1)));
      endcase
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
